// File: rtl/vpu_vec_op.sv
`default_nettype none
// ============================================================================
// Module      : vpu_vec_op
// Description : Multi-lane pipelined FP32 vector op unit. One opcode per beat
//               is applied across LANES lanes behind valid/ready handshakes,
//               with a fixed two-stage (S1 operands, S2 results) latency.
//               Supports ADD, SUB, RELU, MUL, D_RELU, MAX, MIN and a per-lane
//               accumulate (ACC) that folds a burst into one output beat.
// Ports       : clk, rst (async, active-high)
//               in_valid/in_ready, in_opcode, in_last, in_op0, in_op1
//               out_valid/out_ready, out_data
//               err_illegal (sticky, undefined opcode seen)
//               Lane i of any data bus occupies bits [i*DATA_W +: DATA_W].
// Revision    : 1.0 - initial release
// ============================================================================
module vpu_vec_op #(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int OP_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OP_W-1:0]         in_opcode,
    input  logic                    in_last,
    input  logic [LANES*DATA_W-1:0] in_op0,
    input  logic [LANES*DATA_W-1:0] in_op1,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic                    err_illegal
);

    localparam logic [OP_W-1:0] c_OP_ADD    = OP_W'(0);
    localparam logic [OP_W-1:0] c_OP_SUB    = OP_W'(1);
    localparam logic [OP_W-1:0] c_OP_RELU   = OP_W'(2);
    localparam logic [OP_W-1:0] c_OP_MUL    = OP_W'(3);
    localparam logic [OP_W-1:0] c_OP_D_RELU = OP_W'(4);
    localparam logic [OP_W-1:0] c_OP_MAX    = OP_W'(5);
    localparam logic [OP_W-1:0] c_OP_MIN    = OP_W'(6);
    localparam logic [OP_W-1:0] c_OP_ACC    = OP_W'(7);
    localparam logic [31:0]     c_FP_ONE    = 32'h3F80_0000;

    // ------------------------------------------------------------------------
    // FP32 add, round-to-nearest-even. Subnormal inputs/outputs flush to zero;
    // non-finite inputs are not special-cased.
    // ------------------------------------------------------------------------
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       x, y;
        logic [7:0]        ea, eb, d;
        logic [4:0]        dd, lz;
        logic [23:0]       ma, mb;
        logic [53:0]       sh;
        logic [26:0]       ax, bx, n;
        logic [27:0]       s;
        logic signed [9:0] e;
        logic [24:0]       r;
        logic              rnd;
        logic [31:0]       res;
        // x always carries the larger magnitude, so its sign is the result sign
        x  = (b[30:0] > a[30:0]) ? b : a;
        y  = (b[30:0] > a[30:0]) ? a : b;
        ea = x[30:23];
        eb = y[30:23];
        ma = (ea == 8'd0) ? 24'd0 : {1'b1, x[22:0]};
        mb = (eb == 8'd0) ? 24'd0 : {1'b1, y[22:0]};
        d  = ea - eb;
        dd = (d > 8'd31) ? 5'd31 : d[4:0];
        // Align the smaller operand; everything below the guard/round bits
        // is folded into a single sticky bit.
        sh = {mb, 30'd0} >> dd;
        bx = {sh[53:28], sh[27] | (|sh[26:0])};
        ax = {ma, 3'b000};
        s  = (x[31] == y[31]) ? ({1'b0, ax} + {1'b0, bx}) : ({1'b0, ax} - {1'b0, bx});
        e  = $signed({2'b00, ea});
        lz = 5'd0;
        n  = s[26:0];
        res = 32'd0;
        if (ea == 8'd0) begin
            res = {x[31] & y[31], 31'd0};
        end else if (s == 28'd0) begin
            res = 32'd0;                    // exact cancellation gives +0
        end else begin
            if (s[27]) begin
                n = {s[27:2], s[1] | s[0]};
                e = e + 10'sd1;
            end else begin
                for (int k = 0; k < 27; k++) begin
                    if (s[k]) lz = 5'(26 - k);
                end
                n = s[26:0] << lz;
                e = e - $signed({5'd0, lz});
            end
            rnd = n[2] & (n[1] | n[0] | n[3]);
            r   = {1'b0, n[26:3]} + {24'd0, rnd};
            if (r[24]) begin
                r = r >> 1;
                e = e + 10'sd1;
            end
            if (e <= 10'sd0)       res = {x[31], 31'd0};
            else if (e >= 10'sd255) res = {x[31], 8'hFF, 23'd0};
            else                   res = {x[31], e[7:0], r[22:0]};
        end
        return res;
    endfunction

    // FP32 multiply, round-to-nearest-even, same flush/finite assumptions.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic              sg;
        logic [47:0]       p;
        logic [23:0]       m;
        logic              g, st, rnd;
        logic signed [9:0] e;
        logic [24:0]       r;
        logic [31:0]       res;
        sg = a[31] ^ b[31];
        p  = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e  = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (p[47]) begin
            m  = p[47:24];
            g  = p[23];
            st = |p[22:0];
            e  = e + 10'sd1;
        end else begin
            m  = p[46:23];
            g  = p[22];
            st = |p[21:0];
        end
        rnd = g & (st | m[0]);
        r   = {1'b0, m} + {24'd0, rnd};
        if (r[24]) begin
            r = r >> 1;
            e = e + 10'sd1;
        end
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) res = {sg, 31'd0};
        else if (e <= 10'sd0)                       res = {sg, 31'd0};
        else if (e >= 10'sd255)                     res = {sg, 8'hFF, 23'd0};
        else                                        res = {sg, e[7:0], r[22:0]};
        return res;
    endfunction

    // Signed ordering key for sign-magnitude compare; +0 and -0 both map to 0.
    function automatic logic signed [32:0] fp_key(input logic [31:0] v);
        logic signed [32:0] mag;
        mag = $signed({2'b00, v[30:0]});
        return v[31] ? -mag : mag;
    endfunction

    // ------------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------------
    logic                    w_en;
    logic                    w_s1_acc;
    logic                    r_s1_valid;
    logic [OP_W-1:0]         r_s1_op;
    logic                    r_s1_last;
    logic [LANES*DATA_W-1:0] r_s1_op0;
    logic [LANES*DATA_W-1:0] r_s1_op1;
    logic [DATA_W-1:0]       r_acc [LANES];
    logic [LANES*DATA_W-1:0] w_res;
    logic [LANES*DATA_W-1:0] w_sum;
    logic                    w_emit;

    // Every stage advances together; a stalled output freezes the whole pipe.
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;
    assign w_s1_acc = (r_s1_op == c_OP_ACC);
    // A non-final ACC beat only updates the accumulators.
    assign w_emit   = r_s1_valid && !(w_s1_acc && !r_s1_last);

    // ------------------------------------------------------------------------
    // Per-lane datapath
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic [DATA_W-1:0] w_a, w_b, w_add_a, w_add_b, w_sum_l, w_prod, w_r;

            assign w_a = r_s1_op0[i*DATA_W +: DATA_W];
            assign w_b = r_s1_op1[i*DATA_W +: DATA_W];

            always_comb begin
                w_add_a = w_a;
                w_add_b = w_b;
                if (w_s1_acc) begin
                    w_add_a = r_acc[i];
                    w_add_b = w_a;
                end else if (r_s1_op == c_OP_SUB) begin
                    w_add_b = {~w_b[DATA_W-1], w_b[DATA_W-2:0]};
                end
            end

            assign w_sum_l = fp_add(w_add_a, w_add_b);
            assign w_prod  = fp_mul(w_a, w_b);

            always_comb begin
                w_r = '0;
                case (r_s1_op)
                    c_OP_ADD, c_OP_SUB, c_OP_ACC: w_r = w_sum_l;
                    c_OP_RELU:   w_r = w_a[DATA_W-1] ? '0 : w_a;
                    c_OP_MUL:    w_r = w_prod;
                    c_OP_D_RELU: w_r = (!w_a[DATA_W-1] && (w_a[DATA_W-2:0] != '0)) ? c_FP_ONE : '0;
                    c_OP_MAX:    w_r = (fp_key(w_b) > fp_key(w_a)) ? w_b : w_a;
                    c_OP_MIN:    w_r = (fp_key(w_b) < fp_key(w_a)) ? w_b : w_a;
                    default:     w_r = '0;
                endcase
            end

            assign w_res[i*DATA_W +: DATA_W] = w_r;
            assign w_sum[i*DATA_W +: DATA_W] = w_sum_l;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_op     <= '0;
            r_s1_last   <= 1'b0;
            r_s1_op0    <= '0;
            r_s1_op1    <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            err_illegal <= 1'b0;
            for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
        end else begin
            if (in_valid && w_en && (in_opcode > c_OP_ACC)) begin
                err_illegal <= 1'b1;
            end
            if (w_en) begin
                r_s1_valid <= in_valid;
                r_s1_op    <= in_opcode;
                r_s1_last  <= in_last;
                r_s1_op0   <= in_op0;
                r_s1_op1   <= in_op1;
                out_valid  <= w_emit;
                if (w_emit) begin
                    out_data <= w_res;
                end
                // Accumulator write shares the S1->S2 advance, so the next ACC
                // beat in S1 already sees this update.
                if (r_s1_valid && w_s1_acc) begin
                    for (int i = 0; i < LANES; i++) begin
                        r_acc[i] <= r_s1_last ? '0 : w_sum[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
